// File: rtl/dna_ctrl_pkg.sv
// Shared constants and FSM state type for the device-DNA read controller.
package dna_ctrl_pkg;

  localparam int DNA_BITS = 96;
  localparam int CNT_W    = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dna_read_ctrl.sv
// Sequences the external DNA_PORTE2: one READ pulse, 96 shifts, parallel capture
// and a compare against the expected DNA.
module dna_read_ctrl
  import dna_ctrl_pkg::*;
#(
  parameter bit AUTO_READ = 1'b1,
  parameter bit CHECK_EN  = 1'b1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                REQ,
  output logic                ACK,
  output logic                BUSY,
  output logic                DNA_VALID,
  output logic [DNA_BITS-1:0] DNA_VALUE,
  input  logic [DNA_BITS-1:0] EXPECTED_DNA,
  output logic                MATCH,
  output logic                DNA_READ,
  output logic                DNA_SHIFT,
  output logic                DNA_DIN,
  input  logic                DNA_DOUT
);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               auto_pend, auto_pend_n;
  logic               src_req, src_req_n;
  logic               ack_n, busy_n, valid_n, read_n, shift_n;
  logic               capture;

  // Feeding DOUT back into DIN rotates the device register back to its original contents.
  assign DNA_DIN = DNA_DOUT;
  assign MATCH   = CHECK_EN && DNA_VALID && (DNA_VALUE == EXPECTED_DNA);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    auto_pend_n = auto_pend;
    src_req_n   = src_req;
    ack_n       = 1'b0;
    busy_n      = BUSY;
    valid_n     = DNA_VALID;
    read_n      = 1'b0;
    shift_n     = DNA_SHIFT;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        if (REQ || auto_pend) begin
          state_n     = LOAD;
          src_req_n   = REQ;
          auto_pend_n = 1'b0;
          valid_n     = 1'b0;
          read_n      = 1'b1;
          busy_n      = 1'b1;
        end
      end
      LOAD: begin
        state_n = SHIFT;
        shift_n = 1'b1;
        cnt_n   = '0;
      end
      SHIFT: begin
        capture = 1'b1;
        if (cnt == CNT_W'(DNA_BITS - 1)) begin
          state_n = DONE;
          shift_n = 1'b0;
          busy_n  = 1'b0;
          valid_n = 1'b1;
          ack_n   = src_req;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      auto_pend <= AUTO_READ;
      src_req   <= 1'b0;
      ACK       <= 1'b0;
      BUSY      <= 1'b0;
      DNA_VALID <= 1'b0;
      DNA_READ  <= 1'b0;
      DNA_SHIFT <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      auto_pend <= auto_pend_n;
      src_req   <= src_req_n;
      ACK       <= ack_n;
      BUSY      <= busy_n;
      DNA_VALID <= valid_n;
      DNA_READ  <= read_n;
      DNA_SHIFT <= shift_n;
    end
  end

  // Bit k arrives on DOUT k shifts after the load, so cnt doubles as the bit index.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DNA_VALUE <= '0;
    end else if (capture) begin
      DNA_VALUE[cnt] <= DNA_DOUT;
    end
  end

endmodule

// File: tb/tb_dna_read_ctrl.sv
// Bench for dna_read_ctrl: two controllers with behavioural DNA_PORTE2 models,
// a timeline reference model, directed scenarios and randomized traffic.
module tb_dna_read_ctrl;
  import dna_ctrl_pkg::*;

  localparam logic [95:0] SIM_DNA = 96'h0123456789ABCDEF0F1E2D3C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [95:0] exp_dna = SIM_DNA;

  logic ack_a, busy_a, valid_a, match_a, read_a, shift_a, din_a, dout_a;
  logic ack_b, busy_b, valid_b, match_b, read_b, shift_b, din_b, dout_b;
  logic [95:0] value_a, value_b;

  dna_read_ctrl #(.AUTO_READ(1'b0), .CHECK_EN(1'b1)) dut_a (
    .CLK(clk), .RST(rst), .REQ(req_a), .ACK(ack_a), .BUSY(busy_a),
    .DNA_VALID(valid_a), .DNA_VALUE(value_a), .EXPECTED_DNA(exp_dna),
    .MATCH(match_a), .DNA_READ(read_a), .DNA_SHIFT(shift_a),
    .DNA_DIN(din_a), .DNA_DOUT(dout_a));

  dna_read_ctrl #(.AUTO_READ(1'b1), .CHECK_EN(1'b0)) dut_b (
    .CLK(clk), .RST(rst), .REQ(req_b), .ACK(ack_b), .BUSY(busy_b),
    .DNA_VALID(valid_b), .DNA_VALUE(value_b), .EXPECTED_DNA(exp_dna),
    .MATCH(match_b), .DNA_READ(read_b), .DNA_SHIFT(shift_b),
    .DNA_DIN(din_b), .DNA_DOUT(dout_b));

  // Behavioural DNA_PORTE2: READ loads, SHIFT moves DIN into the MSB, DOUT is the LSB.
  logic [95:0] dev_a = ~SIM_DNA;
  logic [95:0] dev_b = 96'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A;
  always @(posedge clk) begin
    if (read_a) dev_a <= SIM_DNA;
    else if (shift_a) dev_a <= {din_a, dev_a[95:1]};
    if (read_b) dev_b <= SIM_DNA;
    else if (shift_b) dev_b <= {din_b, dev_b[95:1]};
  end
  assign dout_a = dev_a[0];
  assign dout_b = dev_b[0];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit ack_b_seen = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ack_b === 1'b1) ack_b_seen <= 1'b1;
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a read is a timeline measured from the edge that accepts it.
  bit          m_active [2];
  int          m_phase  [2];
  bit          m_src    [2];
  bit          m_auto   [2];
  bit          m_valid  [2];
  bit          m_vknown [2];
  logic [95:0] m_value  [2];
  bit          auto_cfg [2] = '{1'b0, 1'b1};
  bit          chk_cfg  [2] = '{1'b1, 1'b0};

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      logic r;
      r = (i == 0) ? req_a : req_b;
      if (rst) begin
        m_active[i] = 1'b0; m_phase[i] = 0; m_src[i] = 1'b0;
        m_auto[i] = auto_cfg[i]; m_valid[i] = 1'b0;
        m_vknown[i] = 1'b1; m_value[i] = '0;
      end else if (m_active[i]) begin
        m_phase[i]++;
        if (m_phase[i] == 97) begin
          m_valid[i] = 1'b1; m_vknown[i] = 1'b1; m_value[i] = SIM_DNA;
        end
        if (m_phase[i] == 98) m_active[i] = 1'b0;
      end else if (r || m_auto[i]) begin
        m_active[i] = 1'b1; m_phase[i] = 0; m_src[i] = r;
        m_auto[i] = 1'b0; m_valid[i] = 1'b0; m_vknown[i] = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 2; i++) begin
      logic a_ack, a_busy, a_valid, a_match, a_read, a_shift, a_din, a_dout;
      logic [95:0] a_value;
      bit e_busy, e_read, e_shift, e_ack, e_match;
      if (i == 0) begin
        a_ack = ack_a; a_busy = busy_a; a_valid = valid_a; a_match = match_a;
        a_read = read_a; a_shift = shift_a; a_din = din_a; a_dout = dout_a; a_value = value_a;
      end else begin
        a_ack = ack_b; a_busy = busy_b; a_valid = valid_b; a_match = match_b;
        a_read = read_b; a_shift = shift_b; a_din = din_b; a_dout = dout_b; a_value = value_b;
      end
      e_busy  = m_active[i] && (m_phase[i] <= 96);
      e_read  = m_active[i] && (m_phase[i] == 0);
      e_shift = m_active[i] && (m_phase[i] >= 1) && (m_phase[i] <= 96);
      e_ack   = m_active[i] && (m_phase[i] == 97) && m_src[i];
      e_match = m_valid[i] && chk_cfg[i] && (SIM_DNA == exp_dna);
      check($sformatf("ack_%0d", i),   96'(a_ack),   96'(e_ack));
      check($sformatf("busy_%0d", i),  96'(a_busy),  96'(e_busy));
      check($sformatf("valid_%0d", i), 96'(a_valid), 96'(m_valid[i]));
      check($sformatf("read_%0d", i),  96'(a_read),  96'(e_read));
      check($sformatf("shift_%0d", i), 96'(a_shift), 96'(e_shift));
      check($sformatf("match_%0d", i), 96'(a_match), 96'(e_match));
      check($sformatf("din_%0d", i),   96'(a_din),   96'(a_dout));
      if (m_vknown[i]) check($sformatf("value_%0d", i), a_value, m_value[i]);
    end
  end

  task automatic run_read(input string tag);
    int n, nr, ns;
    repeat (3) @(negedge clk);
    req_a = 1'b1;
    @(posedge clk); #2;
    n = 0; nr = int'(read_a); ns = int'(shift_a);
    check({tag, "_valid_low"}, 96'(valid_a), 96'(0));
    @(negedge clk) req_a = 1'b0;
    while (ack_a !== 1'b1 && n < 200) begin
      @(posedge clk); #2;
      n++; nr += int'(read_a); ns += int'(shift_a);
    end
    check({tag, "_latency"}, 96'(n), 96'(97));
    check({tag, "_read_cycles"}, 96'(nr), 96'(1));
    check({tag, "_shift_cycles"}, 96'(ns), 96'(96));
    check({tag, "_value"}, value_a, 96'h0123456789ABCDEF0F1E2D3C);
    check({tag, "_valid"}, 96'(valid_a), 96'(1));
  endtask

  initial begin
    int n, t[3], busy_cnt;
    repeat (3) @(negedge clk);
    check("rst_value", value_a, 96'(0));
    check("rst_valid", 96'(valid_a), 96'(0));
    check("rst_busy", 96'(busy_b), 96'(0));

    // Automatic read on instance b
    rst = 1'b0;
    n = 0;
    while (valid_b !== 1'b1 && n < 300) begin
      @(posedge clk); #2; n++;
    end
    check("auto_latency", 96'(n), 96'(98));
    check("auto_value", value_b, 96'h0123456789ABCDEF0F1E2D3C);

    run_read("first");
    @(negedge clk) exp_dna = SIM_DNA;
    @(posedge clk); #2;
    check("match_eq_a", 96'(match_a), 96'(1));
    check("match_eq_b", 96'(match_b), 96'(0));
    @(negedge clk) exp_dna[95] = ~exp_dna[95];
    @(posedge clk); #2;
    check("match_flip_a", 96'(match_a), 96'(0));
    check("match_flip_b", 96'(match_b), 96'(0));
    @(negedge clk) exp_dna = SIM_DNA;

    run_read("second");

    // REQ held high: back-to-back reads
    repeat (3) @(negedge clk);
    req_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin @(posedge clk); #2; n++; end while (ack_a !== 1'b1 && n < 300);
      t[k] = cyc;
    end
    @(negedge clk) req_a = 1'b0;
    check("b2b_period0", 96'(t[1] - t[0]), 96'(99));
    check("b2b_period1", 96'(t[2] - t[1]), 96'(99));

    // REQ toggled while busy must not queue another read
    repeat (3) @(negedge clk);
    req_a = 1'b1;
    @(negedge clk) req_a = 1'b0;
    repeat (10) @(negedge clk) req_a = ~req_a;
    n = 0;
    while (ack_a !== 1'b1 && n < 200) begin @(posedge clk); #2; n++; end
    check("toggle_ack_seen", 96'(ack_a), 96'(1));
    busy_cnt = 0;
    repeat (120) begin @(posedge clk); #2; busy_cnt += int'(busy_a); end
    check("toggle_no_extra", 96'(busy_cnt), 96'(0));

    // Reset in the middle of a read (cnt = 40)
    repeat (3) @(negedge clk);
    req_a = 1'b1;
    @(posedge clk);
    @(negedge clk) req_a = 1'b0;
    repeat (41) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    check("midrst_busy", 96'(busy_a), 96'(0));
    check("midrst_shift", 96'(shift_a), 96'(0));
    check("midrst_read", 96'(read_a), 96'(0));
    check("midrst_valid", 96'(valid_a), 96'(0));
    check("midrst_ack", 96'(ack_a), 96'(0));
    check("midrst_value", value_a, 96'(0));
    check("midrst_match", 96'(match_a), 96'(0));
    @(negedge clk) rst = 1'b0;
    run_read("after_rst");
    check("auto_no_ack", 96'(ack_b_seen), 96'(0));

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      req_a = ($urandom_range(0, 9) == 0);
      req_b = ($urandom_range(0, 19) == 0);
      rst   = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 63) == 0) begin
        case ($urandom_range(0, 2))
          0: exp_dna = SIM_DNA;
          1: exp_dna = SIM_DNA ^ {1'b1, 95'd0};
          default: exp_dna = {$urandom, $urandom, $urandom};
        endcase
      end
    end
    @(negedge clk);
    rst = 1'b0; req_a = 1'b0; req_b = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dna_read_ctrl.md
Name: dna_read_ctrl

Overview:
- Sequences the DNA_PORTE2 primitive: pulses READ, then shifts all 96 device-DNA bits out serially and assembles them into a parallel register.
- Serves one on-demand requester through a REQ/ACK handshake, with an optional automatic read after reset.
- Compares the captured value against an expected DNA so the licensing and board-ID logic gets a single MATCH flag.
- The DNA_PORTE2 instance sits outside this block, in the parent, on the same CLK.

Parameters:
- AUTO_READ, 1, when 1 one read starts automatically after RST deasserts; no ACK for that read.
- CHECK_EN, 1, when 0 the MATCH output is tied 0.

Ports:
- CLK  input  1  system clock; the DNA_PORTE2 CLK pin uses the same net.
- RST  input  1  asynchronous, active-high reset.
- REQ  input  1  read request; level-sensitive, sampled in IDLE only.
- ACK  output  1  one-cycle pulse when a REQ-initiated read completes.
- BUSY  output  1  high in LOAD and SHIFT.
- DNA_VALID  output  1  DNA_VALUE holds a complete capture.
- DNA_VALUE  output  96  captured DNA, bit k = k-th bit shifted out.
- EXPECTED_DNA  input  96  value compared after capture.
- MATCH  output  1  DNA_VALID && CHECK_EN && DNA_VALUE == EXPECTED_DNA.
- DNA_READ  output  1  to DNA_PORTE2 READ.
- DNA_SHIFT  output  1  to DNA_PORTE2 SHIFT.
- DNA_DIN  output  1  to DNA_PORTE2 DIN.
- DNA_DOUT  input  1  from DNA_PORTE2 DOUT.

Behaviour:
- Reset values, asynchronous, all registered outputs: state=IDLE, ACK=0, BUSY=0, DNA_VALID=0, DNA_VALUE=0, DNA_READ=0, DNA_SHIFT=0, cnt=0, auto_pend=AUTO_READ.
- DNA_DIN = DNA_DOUT (combinational loopback). After 96 shifts the device register is rotated back to its original contents.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE: if REQ or auto_pend, go to LOAD. Record src = REQ-initiated if REQ was high, else auto. Clear auto_pend and DNA_VALID. Set DNA_READ=1, BUSY=1.
- LOAD (exactly 1 cycle): at the edge, the device loads and DOUT presents bit0. Go to SHIFT. Set DNA_READ=0, DNA_SHIFT=1, cnt=0.
- SHIFT: at each edge, DNA_VALUE[cnt] <= DNA_DOUT and cnt++.
  - When cnt==95 at the edge: go to DONE, DNA_SHIFT=0, BUSY=0, DNA_VALID=1, ACK=(src==REQ).
  - cnt is 7 bits and never wraps past 95.
- DONE (1 cycle): ACK returns to 0; go to IDLE.
- Latency: REQ sampled at edge t0 → DNA_READ high during t0–t1 → bit k captured at edge t(2+k) → DNA_VALID and ACK high after edge t97. That is 97 cycles; the next request can be sampled at t99.
- Read cycle counts per read: exactly one READ cycle and exactly 96 SHIFT cycles. DNA_READ and DNA_SHIFT are never high together.
- REQ while BUSY: ignored, not queued. A REQ still high in IDLE after DONE starts a new read. The requester drops REQ on ACK.
- REQ and auto_pend together: one read serves both; ACK=1.
- Reset mid-read: abort immediately; DNA_VALID=0. The device register may be partially rotated; the next read re-issues READ, so this is harmless. auto_pend is re-armed.
- MATCH is combinational from registers and EXPECTED_DNA. It is 0 whenever DNA_VALID=0.

Decomposition:
- Package dna_ctrl_pkg:
  - DNA_BITS=96, CNT_W=7.
  - State enum IDLE/LOAD/SHIFT/DONE, binary encoding.
- No sub-module: FSM, counter and capture register live in one module.
- The DNA_PORTE2 instance stays in the parent so the controller simulates without unisims. The bench instantiates DNA_PORTE2 beside it.

Test Plan:
- SIM_DNA_VALUE=96'h0123456789ABCDEF0F1E2D3C, AUTO_READ=0, REQ pulse → ACK one cycle at t97; DNA_VALUE=96'h0123456789ABCDEF0F1E2D3C; DNA_VALID=1; count exactly 1 DNA_READ and 96 DNA_SHIFT cycles.
- AUTO_READ=1, release RST, no REQ → DNA_VALID=1 after 98 cycles with the correct value; ACK never asserted.
- After a full read, issue a second REQ → same value again, proving the loopback rotation preserved the device register; DNA_VALID low during the read.
- REQ held high continuously → back-to-back reads with ACK every 99 cycles; REQ toggled while BUSY → no extra read.
- Assert RST at cnt=40 → all outputs return to reset values immediately; after release, REQ → correct full value.
- EXPECTED_DNA equal to the value → MATCH=1. Flip bit 95 of EXPECTED_DNA → MATCH=0. CHECK_EN=0 → MATCH=0 in both cases.
